// File: rtl/audio_i2s_rx_if.sv
// Byte-stream output of the I2S capture block toward the FIFO write path.
// master = byte producer (audio_i2s_rx), slave = consumer.
interface audio_i2s_rx_if;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       overflow_o;
    logic       frame_o;

    modport master (
        output data_o,
        output valid_o,
        output overflow_o,
        output frame_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        input  overflow_o,
        input  frame_o,
        output ready_i
    );
endinterface

// File: rtl/audio_i2s_rx.sv
// Slave-mode I2S receiver: captures stereo frames and serializes them as bytes.
// Define AUDIO_I2S_RX_LJ_EN for left-justified input instead of standard I2S.
module audio_i2s_rx #(
    parameter int unsigned BIT_DEPTH = 24
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               i2s_bclk_i,
    input  logic               i2s_lrck_i,
    input  logic               i2s_sdata_i,
    audio_i2s_rx_if.master     out_if
);

    localparam int unsigned FRAME_BYTES = 2 * BIT_DEPTH / 8;
    localparam int unsigned FRAME_W     = FRAME_BYTES * 8;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned IDX_W       = 3;
    localparam logic [CNT_W-1:0] BD_CNT = CNT_W'(BIT_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

`ifdef AUDIO_I2S_RX_LJ_EN
    localparam logic LEFT_LVL  = 1'b1;
    localparam logic BIT_DELAY = 1'b0;
`else
    localparam logic LEFT_LVL  = 1'b0;
    localparam logic BIT_DELAY = 1'b1;
`endif

    typedef enum logic [1:0] {C_ALIGN, C_LEFT, C_RIGHT, C_WAIT} cap_state_e;
    typedef enum logic       {S_IDLE, S_SEND}                   ser_state_e;

    // {bclk, lrck, sdata} synchronizer stages
    logic [2:0]           sync1_q, sync1_d, sync2_q, sync2_d;
    logic                 bclk_prev_q, bclk_prev_d;
    logic                 prev_lrck_q, prev_lrck_d;
    logic                 bit_ch_prev_q, bit_ch_prev_d;
    logic [1:0]           seen_q, seen_d;
    cap_state_e           cap_state_q, cap_state_d;
    logic [BIT_DEPTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_DEPTH-1:0] left_q, left_d;
    ser_state_e           ser_state_q, ser_state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FRAME_W-1:0]   frame_buf_q, frame_buf_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overflow_q, overflow_d;
    logic                 frame_q, frame_d;

    logic                 strobe_c, lrck_c, sd_c, bit_ch_c;
    logic                 start_c, left_start_c, right_start_c;
    logic                 commit_c, accept_c, hs_c, last_c;
    logic [CNT_W-1:0]     shamt_c;
    logic [BIT_DEPTH-1:0] shift_in_c, first_bit_c, aligned_c, commit_right_c;
    logic [FRAME_W-1:0]   next_bytes_c;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            bclk_prev_q   <= 1'b0;
            prev_lrck_q   <= 1'b0;
            bit_ch_prev_q <= 1'b0;
            seen_q        <= '0;
            cap_state_q   <= C_ALIGN;
            shift_q       <= '0;
            cnt_q         <= '0;
            left_q        <= '0;
            ser_state_q   <= S_IDLE;
            idx_q         <= '0;
            frame_buf_q   <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            overflow_q    <= 1'b0;
            frame_q       <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            bclk_prev_q   <= bclk_prev_d;
            prev_lrck_q   <= prev_lrck_d;
            bit_ch_prev_q <= bit_ch_prev_d;
            seen_q        <= seen_d;
            cap_state_q   <= cap_state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            left_q        <= left_d;
            ser_state_q   <= ser_state_d;
            idx_q         <= idx_d;
            frame_buf_q   <= frame_buf_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            overflow_q    <= overflow_d;
            frame_q       <= frame_d;
        end
    end

    // Edge detection and channel-start decode; bit_ch is the channel a bit belongs to
    always_comb begin
        sync1_d       = {i2s_bclk_i, i2s_lrck_i, i2s_sdata_i};
        sync2_d       = sync1_q;
        bclk_prev_d   = sync2_q[2];
        strobe_c      = sync2_q[2] & ~bclk_prev_q;
        lrck_c        = sync2_q[1];
        sd_c          = sync2_q[0];
        bit_ch_c      = BIT_DELAY ? prev_lrck_q : lrck_c;
        // history regs hold reset values until two real edges have been seen
        start_c       = strobe_c && (seen_q == 2'd2) && (bit_ch_c != bit_ch_prev_q);
        left_start_c  = start_c && (bit_ch_c == LEFT_LVL);
        right_start_c = start_c && (bit_ch_c != LEFT_LVL);
        shift_in_c    = {shift_q[BIT_DEPTH-2:0], sd_c};
        first_bit_c   = {{(BIT_DEPTH-1){1'b0}}, sd_c};
        shamt_c       = BD_CNT - cnt_q;
        aligned_c     = shift_q << shamt_c;
    end

    // Capture FSM plus byte serializer
    always_comb begin
        prev_lrck_d    = prev_lrck_q;
        bit_ch_prev_d  = bit_ch_prev_q;
        seen_d         = seen_q;
        cap_state_d    = cap_state_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        left_d         = left_q;
        ser_state_d    = ser_state_q;
        idx_d          = idx_q;
        frame_buf_d    = frame_buf_q;
        data_d         = data_q;
        valid_d        = valid_q;
        overflow_d     = overflow_q;
        frame_d        = 1'b0;
        commit_c       = 1'b0;
        commit_right_c = '0;

        if (strobe_c) begin
            prev_lrck_d   = lrck_c;
            bit_ch_prev_d = bit_ch_c;
            if (seen_q != 2'd2) seen_d = seen_q + 2'd1;
            case (cap_state_q)
                C_ALIGN, C_WAIT: begin
                    if (left_start_c) begin
                        cap_state_d = C_LEFT;
                        shift_d     = first_bit_c;
                        cnt_d       = CNT_W'(1);
                    end
                end
                C_LEFT: begin
                    if (right_start_c) begin
                        left_d      = aligned_c;
                        cap_state_d = C_RIGHT;
                        shift_d     = first_bit_c;
                        cnt_d       = CNT_W'(1);
                    end else if (left_start_c) begin
                        shift_d = first_bit_c;
                        cnt_d   = CNT_W'(1);
                    end else if (cnt_q < BD_CNT) begin
                        shift_d = shift_in_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                C_RIGHT: begin
                    if (left_start_c) begin
                        // short right word: commit zero-filled and start the next left
                        commit_c       = 1'b1;
                        commit_right_c = aligned_c;
                        cap_state_d    = C_LEFT;
                        shift_d        = first_bit_c;
                        cnt_d          = CNT_W'(1);
                    end else if (cnt_q < BD_CNT) begin
                        shift_d = shift_in_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == BD_CNT - CNT_W'(1)) begin
                            commit_c       = 1'b1;
                            commit_right_c = shift_in_c;
                            cap_state_d    = C_WAIT;
                        end
                    end
                end
                default: cap_state_d = C_ALIGN;
            endcase
        end

        hs_c         = valid_q && out_if.ready_i;
        last_c       = (idx_q == LAST_IDX);
        next_bytes_c = frame_buf_q << {idx_q + IDX_W'(1), 3'b000};
        accept_c     = commit_c && ((ser_state_q == S_IDLE) || (hs_c && last_c));

        if ((ser_state_q == S_SEND) && hs_c) begin
            if (last_c) begin
                ser_state_d = S_IDLE;
                valid_d     = 1'b0;
            end else begin
                idx_d  = idx_q + IDX_W'(1);
                data_d = next_bytes_c[FRAME_W-1 -: 8];
            end
        end

        if (accept_c) begin
            frame_buf_d = {left_q, commit_right_c};
            ser_state_d = S_SEND;
            idx_d       = '0;
            valid_d     = 1'b1;
            data_d      = left_q[BIT_DEPTH-1 -: 8];
            frame_d     = 1'b1;
        end else if (commit_c) begin
            overflow_d = 1'b1;
        end
    end

    assign out_if.data_o     = data_q;
    assign out_if.valid_o    = valid_q;
    assign out_if.overflow_o = overflow_q;
    assign out_if.frame_o    = frame_q;

endmodule
